// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - multi-cycle load/store unit driving a synchronous byte-enabled data RAM
module dm_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [2:0]                            req_ctrl,
  input  logic [DATA_W-1:0]                     req_wdata,
  output logic                                  resp_valid,
  output logic                                  resp_err,
  output logic [DATA_W-1:0]                     resp_rdata,
  output logic                                  mem_en,
  output logic [DATA_W/8-1:0]                   mem_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_addr,
  output logic [DATA_W-1:0]                     mem_wdata,
  input  logic [DATA_W-1:0]                     mem_rdata
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam logic [2*B-1:0]   MASK_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;

  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_WAIT, S_RESP} state_t;

  state_t               state;
  logic                 we_q;
  logic [OFF_W-1:0]     off_q;
  logic [3:0]           size_q;
  logic                 signed_q;
  logic                 split_q;
  logic [B-1:0]         mask_hi_q;
  logic [DATA_W-1:0]    data_hi_q;
  logic [DATA_W-1:0]    beat1_q;
  logic                 mem_en_q;
  logic [B-1:0]         mem_we_q;
  logic [IDX_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;

  // Request decode, evaluated on the live request fields at accept time
  logic [OFF_W-1:0]     req_off;
  logic [3:0]           req_size;
  logic                 req_signed;
  logic                 ctrl_ok;
  logic                 req_split;
  logic                 req_illegal;
  logic [DATA_W-1:0]    size_keep;
  logic [2*B-1:0]       lane_mask;
  logic [2*DATA_W-1:0]  lane_data;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    req_size   = 4'd4;
    req_signed = 1'b1;
    ctrl_ok    = 1'b1;
    case (req_ctrl)
      3'b000: begin req_size = 4'd4; req_signed = 1'b1; end
      3'b001: begin req_size = 4'd2; req_signed = 1'b1; end
      3'b010: begin req_size = 4'd2; req_signed = 1'b0; end
      3'b011: begin req_size = 4'd1; req_signed = 1'b1; end
      3'b100: begin req_size = 4'd1; req_signed = 1'b0; end
      3'b101: begin req_size = 4'd8; req_signed = 1'b0; ctrl_ok = (DATA_W == 64); end
      default: ctrl_ok = 1'b0;
    endcase
    req_split   = (int'(req_off) + int'(req_size)) > B;
    req_illegal = !ctrl_ok || (req_split && !MISALIGN_EN);
    size_keep   = ~({DATA_W{1'b1}} << (8 * req_size));
    lane_mask   = ((MASK_ONE << req_size) - MASK_ONE) << req_off;
    lane_data   = {{DATA_W{1'b0}}, req_wdata & size_keep} << (8 * req_off);
  end

  // Final-beat merge; only meaningful while in S_WAIT, result goes straight into a register
  logic [DATA_W-1:0]    fin_b1;
  logic [DATA_W-1:0]    fin_b2;
  logic [2*DATA_W-1:0]  ld_shift;
  logic [DATA_W-1:0]    ld_raw;
  logic [DATA_W-1:0]    ld_keep;
  logic                 ld_msb;
  logic [DATA_W-1:0]    ld_ext;

  always_comb begin
    fin_b1   = split_q ? beat1_q : mem_rdata;
    fin_b2   = split_q ? mem_rdata : {DATA_W{1'b0}};
    ld_shift = {fin_b2, fin_b1} >> (8 * off_q);
    ld_raw   = ld_shift[DATA_W-1:0];
    ld_keep  = ~({DATA_W{1'b1}} << (8 * size_q));
    case (size_q)
      4'd1:    ld_msb = ld_raw[7];
      4'd2:    ld_msb = ld_raw[15];
      4'd4:    ld_msb = ld_raw[31];
      default: ld_msb = 1'b0;
    endcase
    ld_ext = (ld_raw & ld_keep) | ({DATA_W{signed_q & ld_msb}} & ~ld_keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      off_q       <= '0;
      size_q      <= 4'd0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      mask_hi_q   <= '0;
      data_hi_q   <= '0;
      beat1_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state       <= S_ACC1;
              we_q        <= req_we;
              off_q       <= req_off;
              size_q      <= req_size;
              signed_q    <= req_signed;
              split_q     <= req_split;
              mask_hi_q   <= lane_mask[2*B-1:B];
              data_hi_q   <= lane_data[2*DATA_W-1:DATA_W];
              mem_en_q    <= 1'b1;
              mem_addr_q  <= req_addr[ADDR_W-1:OFF_W];
              mem_we_q    <= req_we ? lane_mask[B-1:0] : '0;
              mem_wdata_q <= lane_data[DATA_W-1:0];
            end
          end
        end
        S_ACC1: begin
          if (split_q) begin
            state       <= S_ACC2;
            mem_addr_q  <= mem_addr_q + IDX_ONE;
            mem_we_q    <= we_q ? mask_hi_q : '0;
            mem_wdata_q <= data_hi_q;
          end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= '0;
            if (we_q) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_ACC2: begin
          mem_en_q <= 1'b0;
          mem_we_q <= '0;
          if (we_q) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end else begin
            beat1_q <= mem_rdata;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!split_q) beat1_q <= mem_rdata;
          resp_rdata <= ld_ext;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset must silence the RAM in the same cycle, before the registered strobes clear
  assign mem_en    = mem_en_q & ~rst;
  assign mem_we    = mem_we_q & {B{~rst}};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign req_ready = (state == S_IDLE) & ~rst;

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Parametrised, multi-cycle successor to the combinational data-memory controller. Accepts one load/store request at a time from the MEM stage over a valid/ready handshake. Drives a synchronous byte-enabled data RAM (1-cycle read latency). Splits misaligned accesses into two aligned beats, merges and sign/zero-extends load data, and flags illegal requests.

Parameters:
DATA_W, 32, memory word width in bits; 32 or 64.
ADDR_W, 32, byte-address width.
MISALIGN_EN, 1, 1 = split misaligned accesses into two beats; 0 = reject them with resp_err.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_ctrl  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned, 101 dword (DATA_W=64 only)
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid; illegal ctrl or rejected misalignment
resp_rdata  out  DATA_W  extended load data; valid with resp_valid
mem_en  out  1  RAM access strobe
mem_we  out  DATA_W/8  byte write enables
mem_addr  out  ADDR_W-log2(DATA_W/8)  word index
mem_wdata  out  DATA_W  lane-aligned write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en

Behaviour:
- Definitions: B=DATA_W/8; off=req_addr mod B; s = size in bytes (1/2/4/8); split = off+s > B.
- Accept = req_valid & req_ready; request fields latched at accept. req_ready=0 in all non-IDLE states.
- Illegal: ctrl 110/111, 101 when DATA_W=32, or split with MISALIGN_EN=0. Takes IDLE->RESP directly, with no mem_en, resp_err=1, resp_rdata=0.
- States and transitions:
  IDLE -> ACC1 on a legal accept.
  ACC1 -> ACC2 if split; else WAIT for a load; else RESP.
  ACC2 -> WAIT for a load; else RESP.
  WAIT -> RESP.
  RESP -> IDLE.
- ACC1 drives mem_en=1, mem_addr=word index of req_addr.
- ACC2 drives mem_en=1, mem_addr = previous index + 1, wrapping modulo 2^width. For a load, ACC2 also captures beat-1 mem_rdata.
- WAIT captures the final beat of mem_rdata.
- RESP drives resp_valid=1 for exactly one cycle.
- Lane math: 2B-bit mask = ((1<<s)-1)<<off; write data = {0,wdata[8s-1:0]}<<(8*off).
  - Beat 1 uses the low half of mask and data; beat 2 uses the high half.
  - Load: {beat2,beat1}>>(8*off); keep s bytes; sign-extend for signed ctrl, zero-extend otherwise.
  - For a non-split load, beat2 is treated as 0.
- Load enables: mem_we=0 on loads; mem_we, mem_en=0 outside ACC1/ACC2.
- Latency (accept = cycle 0), resp_valid in cycle:
  - aligned store: 2
  - split store: 3
  - aligned load: 3
  - split load: 4
  - illegal: 1
- resp_rdata comes from internal registers only, with no combinational path from mem_rdata. It holds until the next load response; stores leave it unchanged.
- Reset: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, captured beats=0.
  - mem_en and mem_we are gated low combinationally while rst=1.
  - req_ready=0 while rst=1 and =1 in the first cycle after release.
- Reset mid-operation aborts the access: no further beats, no response. A beat already written is not undone.
- req_valid held while busy is ignored and not accepted until IDLE.

Test Plan:
1. sw 0x100, data 0xDEADBEEF -> cycle 1: mem_addr=0x40, mem_we=1111, mem_wdata=0xDEADBEEF; resp_valid cycle 2, resp_err=0.
2. sb 0x103, data 0x000000A5 -> mem_we=1000, mem_wdata=0xA5000000. Then lb 0x103 with mem word 0xA5000000 -> resp_rdata=0xFFFFFFA5 in cycle 3; lbu -> 0x000000A5.
3. Split sw 0x102, data 0x11223344 -> cycle 1: addr 0x40, we 1100, wdata 0x33440000; cycle 2: addr 0x41, we 0011, wdata 0x00001122; resp_valid cycle 3.
4. Split lh 0x103, mem[0x40]=0x8C000000, mem[0x41]=0x000000F1 -> resp_rdata=0xFFFFF18C in cycle 4; lhu -> 0x0000F18C.
5. MISALIGN_EN=0: lw 0x101 -> no mem_en, resp_valid+resp_err in cycle 1, rdata 0. ctrl=111 gives the same result. req_valid held in RESP -> not accepted until IDLE.
6. rst pulsed during ACC1 of split store -> no second beat, no resp_valid; req_ready=1 one cycle after rst falls, and the next aligned lw completes normally.
